mem_word_streamer: RTL
======================

MEM_WORD_STREAMER -- requirements
Module: mem_word_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory/stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2), output buffer entries.
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse launching a transfer.
REQ-007 SHALL have port base_addr  in  ADDR_W  first word address, sampled on start.
REQ-008 SHALL have port length  in  ADDR_W+1  word count 0..4096, sampled on start.
REQ-009 SHALL have port busy  out  1  transfer in progress.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_address  out  ADDR_W  memory word address.
REQ-012 SHALL have port mem_chipselect  out  1  read request qualifier.
REQ-013 SHALL have ports mem_write (const 0), mem_byteenable (4 bits, const all-ones), mem_clken (const 1), all outputs.
REQ-014 SHALL have port mem_readdata  in  DATA_W  memory data, valid 1 cycle after request.
REQ-015 SHALL have ports out_data (out, DATA_W), out_valid (out, 1), out_ready (in, 1), out_last (out, 1): downstream stream.

Function
REQ-016 SHALL implement states IDLE, READ, DRAIN; IDLE->READ on start with length>0; READ->DRAIN after last request issued; DRAIN->IDLE when last word accepted.
REQ-017 SHALL, on start with length=0, stay in IDLE, issue no request and pulse done the next cycle.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL issue a read (mem_chipselect=1) in READ only when fifo_count + in_flight < FIFO_DEPTH, counting the accepted output of the same cycle as freed.
REQ-020 SHALL treat read latency as exactly 1 cycle: mem_readdata written into the FIFO the cycle after a request.
REQ-021 SHALL increment mem_address by 1 per request, wrapping modulo 2^ADDR_W (4095->0).
REQ-022 SHALL sustain one word per cycle when out_ready is held 1.
REQ-023 SHALL present FIFO head on out_data with out_valid=1 whenever non-empty; transfer occurs on out_valid & out_ready.
REQ-024 SHALL hold out_data/out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL assert out_last with the final word of the transfer only.
REQ-026 SHALL pulse done the cycle after the final word is accepted; busy=1 from the cycle after start through the done cycle.
REQ-027 SHALL support simultaneous FIFO write and read when full (count unchanged).

Reset
REQ-028 SHALL on reset_n=0 asynchronously force IDLE, busy=0, done=0, out_valid=0, out_last=0, mem_chipselect=0, mem_address=0, FIFO empty, counters 0.
REQ-029 SHALL, on reset mid-transfer, discard in-flight data and buffered words; no done pulse.

Configuration
REQ-030 SHALL, with STREAMER_SUM_EN defined, add output sum_out (DATA_W), modulo-2^DATA_W sum of words accepted downstream, cleared on accepted start, held after done.
REQ-031 SHALL, without STREAMER_SUM_EN, omit sum_out and its adder entirely.

Structure
REQ-032 SHALL place the state enum type and default ADDR_W/DATA_W constants in shared package streamer_pkg.
REQ-033 SHALL implement the buffer as sub-module streamer_fifo (synchronous, first-word-fall-through, count output).

Verification
REQ-034 SHALL cover: base_addr=0x010, length=8, out_ready=1 -> data of 0x010..0x017 in order, 8 consecutive transfers, out_last on 8th, done once.
REQ-035 SHALL cover: base_addr=0xFFE, length=4 -> addresses 0xFFE,0xFFF,0x000,0x001 returned in order.
REQ-036 SHALL cover: length=16, out_ready toggled 1/0 randomly -> no word lost/duplicated, in_flight+count never exceeds 4, data stable when stalled.
REQ-037 SHALL cover: start with length=0 -> no mem_chipselect, done 1 cycle later; second start while busy -> ignored.
REQ-038 SHALL cover: reset_n low at 5th word of 16 -> all outputs at reset values immediately; fresh start length=2 then completes correctly.
REQ-039 SHALL cover (STREAMER_SUM_EN): words 0xFFFFFFFF,0x00000002 -> sum_out=0x00000001 after done.

Source files
------------

// File: rtl/mem_word_streamer_pkg.sv
// Shared types and default widths for the memory word streamer.
package streamer_pkg;

  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/mem_word_streamer_if.sv
// Memory read bus plus downstream valid/ready stream of the word streamer.
interface mem_word_streamer_if
  import streamer_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  out_data, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/mem_word_streamer_fifo.sv
// First-word-fall-through output buffer; a write and a read may share a cycle even when full.
module streamer_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && ((count != CNT_W'(DEPTH)) || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mem_word_streamer.sv
// Streams a block of memory words out over valid/ready with one-cycle read latency.
// Define STREAMER_SUM_EN to add sum_out, the running sum of accepted words.
module mem_word_streamer
  import streamer_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
`ifdef STREAMER_SUM_EN
  output logic [DATA_W-1:0] sum_out,
`endif
  mem_word_streamer_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int LEN_W = ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  req_left;
  logic [LEN_W-1:0]  out_left;
  logic              in_flight;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occupancy;
  logic              issue;
  logic              pop;
  logic              take_start;

  // Slots already claimed after this edge; a word leaving this cycle frees its slot.
  assign occupancy  = {1'b0, fifo_count} + OCC_W'(in_flight) - OCC_W'(pop);
  assign issue      = (state == READ) && (req_left != '0) &&
                      (occupancy < OCC_W'(FIFO_DEPTH));
  assign pop        = bus.out_valid && bus.out_ready;
  assign take_start = (state == IDLE) && start && !busy;

  assign bus.mem_address    = addr;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;
  assign bus.out_valid      = (fifo_count != '0);
  assign bus.out_last       = bus.out_valid && (out_left == LEN_W'(1));

  streamer_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (in_flight),
    .wr_data (bus.mem_readdata),
    .rd_en   (pop),
    .rd_data (bus.out_data),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr      <= '0;
      req_left  <= '0;
      out_left  <= '0;
      in_flight <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= issue;
      if (issue) begin
        addr     <= addr + ADDR_W'(1);
        req_left <= req_left - LEN_W'(1);
      end
      if (pop) out_left <= out_left - LEN_W'(1);

      case (state)
        IDLE: begin
          // busy covers the done cycle, so a start landing there is ignored too
          if (done) busy <= 1'b0;
          if (take_start) begin
            addr     <= base_addr;
            req_left <= length;
            out_left <= length;
            busy     <= 1'b1;
            if (length == '0) done  <= 1'b1;
            else              state <= READ;
          end
        end
        READ: begin
          if (issue && (req_left == LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (out_left == LEN_W'(1))) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STREAMER_SUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        sum_out <= '0;
    else if (take_start) sum_out <= '0;
    else if (pop)        sum_out <= sum_out + bus.out_data;
  end
`endif

endmodule
